// File: rtl/k12a_spi_master.sv
// SPI master beside k12a_io: full-duplex DATA_WIDTH-bit shifts in all four CPOL/CPHA
// modes, programmable SCK divider, MSB/LSB-first ordering and one-hot active-low selects.
module k12a_spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  cpu_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CS_W-1:0]       cs_index,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [NUM_CS-1:0]     spi_cs_n
);
    localparam int ECW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state, state_next;

    logic [DIV_WIDTH-1:0]  div_cnt, div_lat;
    logic [ECW-1:0]        edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh;
    logic                  cpol_l, cpha_l, lsb_l;
    logic                  tick, accept, sck_edge, finish, leading, sample, drive;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                         input logic lsb);
        return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // LSB-first enters at the top so the first bit received ends up in bit 0.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                        input logic b, input logic lsb);
        return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == CS_W'(i)) r[i] = 1'b0;
        end
        return r;
    endfunction

    always_ff @(posedge cpu_clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // One tick per half-period; XFER turns each tick into an SCK edge.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sck_edge   = 1'b0;
        finish     = 1'b0;
        tick       = (div_cnt == div_lat);
        leading    = ~edge_cnt[0];
        case (state)
            IDLE:    if (start) begin
                         accept     = 1'b1;
                         state_next = SETUP;
                     end
            SETUP:   if (tick) state_next = XFER;
            XFER:    if (tick) begin
                         sck_edge = 1'b1;
                         if (edge_cnt == LAST_EDGE) state_next = HOLD;
                     end
            HOLD:    if (tick) begin
                         finish     = 1'b1;
                         state_next = IDLE;
                     end
            default: state_next = IDLE;
        endcase
        sample = sck_edge & (leading ^ cpha_l);
        drive  = sck_edge & (cpha_l ? leading : (~leading && edge_cnt != LAST_EDGE));
    end

    always_ff @(posedge cpu_clock) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
            div_cnt  <= '0;
            div_lat  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;

            if (state == IDLE) begin
                spi_sck <= cpol;
                if (accept) begin
                    busy     <= 1'b1;
                    tx_sh    <= tx_data;
                    rx_sh    <= '0;
                    div_lat  <= clk_div;
                    cpol_l   <= cpol;
                    cpha_l   <= cpha;
                    lsb_l    <= lsb_first;
                    edge_cnt <= '0;
                    spi_cs_n <= cs_decode(cs_index);
                    spi_mosi <= cpha ? 1'b0 : first_bit(tx_data, lsb_first);
                end
            end

            if (sck_edge) begin
                spi_sck  <= ~spi_sck;
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (sample) rx_sh <= shift_in(rx_sh, spi_miso, lsb_l);
            // cpha=0 already shows the current bit, so it moves to the next one.
            if (drive) begin
                spi_mosi <= cpha_l ? first_bit(tx_sh, lsb_l)
                                   : first_bit(shift_out(tx_sh, lsb_l), lsb_l);
                tx_sh    <= shift_out(tx_sh, lsb_l);
            end

            if (finish) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                rx_data  <= rx_sh;
                spi_cs_n <= '1;
                spi_mosi <= 1'b0;
                spi_sck  <= cpol_l;
            end
        end
    end
endmodule

// File: tb/tb_k12a_spi_master.sv
// Bench for k12a_spi_master: directed transfers against a loopback or an SPI slave
// model, with expected rx words queued at start and popped at done.
module tb_k12a_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset_n = 1'b0;
    logic       a_start = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0, a_lsb = 1'b0;
    logic [7:0] a_tx = 8'h00, a_div = 8'h00;
    logic [1:0] a_cs = 2'd0;
    logic       a_busy, a_done, a_sck, a_mosi, a_miso;
    logic [7:0] a_rx;
    logic [3:0] a_cs_n;
    logic       loop = 1'b1;
    logic       slv_miso = 1'b0;
    assign a_miso = loop ? a_mosi : slv_miso;

    logic        b_start = 1'b0;
    logic [15:0] b_tx = 16'h0000;
    logic        b_busy, b_done, b_sck, b_mosi;
    logic [15:0] b_rx;
    logic [3:0]  b_cs_n;

    k12a_spi_master #(.DATA_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) dut_a (
        .cpu_clock(clk), .reset_n(reset_n), .start(a_start), .tx_data(a_tx),
        .cs_index(a_cs), .clk_div(a_div), .cpol(a_cpol), .cpha(a_cpha),
        .lsb_first(a_lsb), .busy(a_busy), .done(a_done), .rx_data(a_rx),
        .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso), .spi_cs_n(a_cs_n)
    );

    k12a_spi_master #(.DATA_WIDTH(16), .NUM_CS(4), .DIV_WIDTH(8)) dut_b (
        .cpu_clock(clk), .reset_n(reset_n), .start(b_start), .tx_data(b_tx),
        .cs_index(2'd3), .clk_div(8'd0), .cpol(1'b0), .cpha(1'b0),
        .lsb_first(1'b0), .busy(b_busy), .done(b_done), .rx_data(b_rx),
        .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_mosi), .spi_cs_n(b_cs_n)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Bus monitor and slave model for dut_a, evaluated away from the active edge.
    logic       prev_busy = 1'b0, prev_sck = 1'b0, prev_mosi = 1'b0, prev_sel = 1'b0;
    int         rise_cyc = 0, last_tog = 0, tog_cnt = 0, hp_err = 0, mosi_err = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] slv_word = 8'h00;
    logic       slv_lsb = 1'b0;
    int         slv_ptr = 0;
    logic       sel;
    assign sel = (a_cs_n != 4'hF);

    function automatic logic sbit(input int i);
        if (i < 0 || i > 7) return 1'b0;
        return slv_lsb ? slv_word[i] : slv_word[7-i];
    endfunction

    always @(negedge clk) begin
        logic leading, samp;
        leading = (prev_sck == a_cpol);
        samp    = a_cpha ? !leading : leading;
        prev_busy <= a_busy;
        prev_sck  <= a_sck;
        prev_mosi <= a_mosi;
        prev_sel  <= sel;
        if (a_busy && !prev_busy) begin
            rise_cyc <= cyc;
            tog_cnt  <= 0;
            hp_err   <= 0;
            mosi_err <= 0;
            cap      <= 8'h00;
        end else if (a_busy) begin
            if (a_sck != prev_sck) begin
                tog_cnt  <= tog_cnt + 1;
                if (tog_cnt > 0 && (cyc - last_tog) != int'(a_div) + 1) hp_err <= hp_err + 1;
                last_tog <= cyc;
                if (samp) cap <= {cap[6:0], a_mosi};
            end
            if (a_mosi != prev_mosi && !(prev_sck && !a_sck)) mosi_err <= mosi_err + 1;
        end
        if (sel && !prev_sel) begin
            slv_miso <= a_cpha ? 1'b0 : sbit(0);
            slv_ptr  <= a_cpha ? 0 : 1;
        end else if (sel && a_sck != prev_sck && (a_cpha ? leading : !leading)) begin
            slv_miso <= sbit(slv_ptr);
            slv_ptr  <= slv_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup_a(input logic [7:0] div, input logic [1:0] cs, input logic pol,
                           input logic pha, input logic lsb);
        a_div = div; a_cs = cs; a_cpol = pol; a_cpha = pha; a_lsb = lsb;
        repeat (3) @(negedge clk);
    endtask

    task automatic kick_a(input logic [7:0] tx, input logic [7:0] exp);
        a_tx    = tx;
        a_start = 1'b1;
        exp_q.push_back(32'(exp));
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        logic [31:0] e;
        n = 0;
        while (a_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(a_done), 32'd1);
        if (a_done === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check({tag, "_rx"}, 32'(a_rx), e);
            check({tag, "_lat"}, 32'(cyc - rise_cyc), 32'(exp_lat));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, n, c0;
        logic [31:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_rx", 32'(a_rx), 32'd0);
        check("rst_sck", 32'(a_sck), 32'd0);
        check("rst_mosi", 32'(a_mosi), 32'd0);
        check("rst_cs", 32'(a_cs_n), 32'hF);
        reset_n = 1'b1;
        @(negedge clk);

        // Mode 0 loopback, cs 1
        loop = 1'b1;
        setup_a(8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        kick_a(8'hA5, 8'hA5);
        repeat (3) @(negedge clk);
        check("m0_cs_during", 32'(a_cs_n), 32'hD);
        wait_done("m0", 18);
        check("m0_cs_after", 32'(a_cs_n), 32'hF);
        check("m0_mosi_bits", 32'(cap), 32'hA5);

        // Mode 3, divider 2, slave answers 0xC3
        loop = 1'b0; slv_word = 8'hC3; slv_lsb = 1'b0;
        setup_a(8'd2, 2'd0, 1'b1, 1'b1, 1'b0);
        check("m3_sck_idle", 32'(a_sck), 32'd1);
        kick_a(8'h3C, 8'hC3);
        wait_done("m3", 54);
        check("m3_half_period", 32'(hp_err), 32'd0);
        check("m3_mosi_on_fall", 32'(mosi_err), 32'd0);
        check("m3_edges", 32'(tog_cnt), 32'd16);
        check("m3_mosi_bits", 32'(cap), 32'h3C);

        // LSB-first, mode 1
        slv_word = 8'h80; slv_lsb = 1'b1;
        setup_a(8'd0, 2'd2, 1'b0, 1'b1, 1'b1);
        kick_a(8'h01, 8'h80);
        wait_done("lsb", 18);
        check("lsb_mosi_bits", 32'(cap), 32'h80);

        // Start while busy ignored, start in done cycle accepted
        slv_word = 8'h99; slv_lsb = 1'b0;
        setup_a(8'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        kick_a(8'h66, 8'h99);
        repeat (12) @(negedge clk);
        a_tx = 8'hFF; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done("b2b1", 36);
        check("b2b1_mosi_bits", 32'(cap), 32'h66);
        slv_word = 8'h5A;
        kick_a(8'h12, 8'h5A);
        check("b2b_busy_again", 32'(a_busy), 32'd1);
        wait_done("b2b2", 36);
        check("b2b2_mosi_bits", 32'(cap), 32'h12);
        repeat (5) @(negedge clk);
        check("b2b_no_queue", 32'(a_busy), 32'd0);

        // Reset at bit 4 aborts with no done
        loop = 1'b1;
        setup_a(8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        kick_a(8'hF0, 8'hF0);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_cs", 32'(a_cs_n), 32'hF);
        check("abort_sck", 32'(a_sck), 32'd0);
        check("abort_rx", 32'(a_rx), 32'd0);
        reset_n = 1'b1;
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (a_done === 1'b1) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        exp_q.delete();

        // 16-bit instance, cs 3, loopback
        b_tx = 16'hBEEF; b_start = 1'b1;
        exp_q.push_back(32'h0000BEEF);
        @(negedge clk);
        b_start = 1'b0;
        c0 = cyc;
        @(negedge clk);
        check("w16_cs_during", 32'(b_cs_n), 32'h7);
        n = 0;
        while (b_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("w16_done", 32'(b_done), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("w16_rx", 32'(b_rx), e);
        check("w16_lat", 32'(cyc - c0), 32'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
